// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: default sizing and
// the channel assignment used by the mp4 top level when wiring strobes.
package perf_pkg;

   // Default bank sizing
   localparam int PERF_NUM_CH = 8;
   localparam int PERF_CNT_W  = 32;

   // Event channel indices (strobe sources in the CPU, caches and arbiter)
   localparam int PERF_COMMIT = 0;
   localparam int PERF_IREQ   = 1;
   localparam int PERF_IHIT   = 2;
   localparam int PERF_DREQ   = 3;
   localparam int PERF_DHIT   = 4;
   localparam int PERF_BR     = 5;
   localparam int PERF_BRMISS = 6;

endpackage

// File: rtl/perf_counter.sv
// Single live event counter with a sticky overflow flag.
// SAT=1 holds at the maximum value; SAT=0 wraps to zero. Either way the
// overflow flag is set when an increment arrives while the count is at max.
module perf_counter
   import perf_pkg::*;
#(
   parameter int CNT_W = PERF_CNT_W,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   // Count gated strobes; clear beats any simultaneous increment
   // NOTE: flops use non-blocking assignments so every reader sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (i_clear) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (i_en && i_inc) begin
         if (r_cnt == CNT_MAX) begin
            r_ovf <= 1'b1;
            if (!SAT) begin
               r_cnt <= '0;
            end
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_cnt = r_cnt;
   assign o_ovf = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters plus a free-running cycle counter.
// A snap copies every live counter and overflow flag into shadow registers
// in one edge so that ratios are computed from a single coherent instant.
// Reads return shadow values one cycle after rd_en; a snap in the same
// cycle as rd_en is already visible in that read.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int                NUM_CH   = PERF_NUM_CH,
   parameter int                CNT_W    = PERF_CNT_W,
   parameter logic [NUM_CH-1:0] SAT_MASK = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         enable,
   input  logic [NUM_CH-1:0]            event_i,
   input  logic                         snap,
   input  logic                         rd_en,
   input  logic [$clog2(NUM_CH+1)-1:0]  rd_sel,
   output logic                         rd_valid,
   output logic [CNT_W-1:0]             rd_data,
   output logic                         rd_ovf,
   output logic [NUM_CH:0]              ovf_o
);

   localparam int               SEL_W   = $clog2(NUM_CH+1);
   localparam logic [SEL_W-1:0] CYC_SEL = SEL_W'(NUM_CH);

   // Index NUM_CH is the cycle counter throughout
   logic [NUM_CH:0][CNT_W-1:0] w_live_cnt;
   logic [NUM_CH:0]            w_live_ovf;
   logic [NUM_CH:0][CNT_W-1:0] w_src_cnt;
   logic [NUM_CH:0]            w_src_ovf;
   logic [CNT_W-1:0]           w_rd_data;
   logic                       w_rd_ovf;

   logic [NUM_CH:0][CNT_W-1:0] r_sh_cnt;
   logic [NUM_CH:0]            r_sh_ovf;
   logic                       r_rd_valid;
   logic [CNT_W-1:0]           r_rd_data;
   logic                       r_rd_ovf;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      perf_counter #(
         .CNT_W (CNT_W),
         .SAT   (SAT_MASK[g])
      ) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .i_clear (clear),
         .i_en    (enable),
         .i_inc   (event_i[g]),
         .o_cnt   (w_live_cnt[g]),
         .o_ovf   (w_live_ovf[g])
      );
   end

   perf_counter #(
      .CNT_W (CNT_W),
      .SAT   (1'b0)
   ) u_cycle (
      .clk     (clk),
      .rst     (rst),
      .i_clear (clear),
      .i_en    (enable),
      .i_inc   (1'b1),
      .o_cnt   (w_live_cnt[NUM_CH]),
      .o_ovf   (w_live_ovf[NUM_CH])
   );

   // Capture pre-edge live values on snap; clear and enable do not touch shadows
   // NOTE: shadows are reset because their contents are visible on rd_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_cnt <= '0;
         r_sh_ovf <= '0;
      end else if (snap) begin
         r_sh_cnt <= w_live_cnt;
         r_sh_ovf <= w_live_ovf;
      end
   end

   // Select what the shadows hold after this edge, then the requested entry
   // NOTE: outputs get defaults first so no branch leaves them unassigned.
   always_comb begin
      w_src_cnt = snap ? w_live_cnt : r_sh_cnt;
      w_src_ovf = snap ? w_live_ovf : r_sh_ovf;
      w_rd_data = '0;
      w_rd_ovf  = 1'b0;
      if (rd_sel <= CYC_SEL) begin
         w_rd_data = w_src_cnt[rd_sel];
         w_rd_ovf  = w_src_ovf[rd_sel];
      end
   end

   // Registered read port; data holds when no read is requested
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_rd_ovf   <= 1'b0;
      end else begin
         r_rd_valid <= rd_en;
         if (rd_en) begin
            r_rd_data <= w_rd_data;
            r_rd_ovf  <= w_rd_ovf;
         end
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign rd_ovf   = r_rd_ovf;
   assign ovf_o    = w_live_ovf;

endmodule
